// File: rtl/tile_writeback_pkg.sv
// Shared constants, state encoding and pixel conversion for the tile writeback path.
// The tile buffer holds u0.10 RGBA entries; the framebuffer side takes packed 8-bit RGBA.
package tile_writeback_pkg;

  localparam int TILE_W      = 32;
  localparam int TILE_H      = 32;
  localparam int TILE_AW     = 10;
  localparam int TILE_PIXELS = TILE_W * TILE_H;
  localparam int U010_MAX    = 1023;

  localparam int CH_W  = 16;
  localparam int R_LSB = 0;
  localparam int G_LSB = 16;
  localparam int B_LSB = 32;
  localparam int A_LSB = 48;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_RUN   = 2'd1,
    WB_FLUSH = 2'd2,
    WB_DONE  = 2'd3
  } wb_state_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] rgba;
  } fb_pixel_t;

  // Values above 1.0 (anything past 1023) clamp to full intensity.
  function automatic logic [7:0] unorm10_to_u8(input logic [CH_W-1:0] v);
    logic [9:0] sat;
    sat = (v > 16'(U010_MAX)) ? 10'(U010_MAX) : v[9:0];
    return sat[9:2];
  endfunction

endpackage

// File: rtl/tile_wb_fifo.sv
// Small synchronous FIFO holding converted pixels until the framebuffer writer accepts them.
// The head reads as zero while empty so the downstream bus is quiet between tiles.
module tile_wb_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/tile_writeback.sv
// Drains a finished tile buffer to the framebuffer writer in row-major order,
// clearing each entry to the background value right after it has been read.
module tile_writeback
  import tile_writeback_pkg::*;
#(
  parameter logic [63:0] CLEAR_RGBA = 64'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         tile_px,
  input  logic [15:0]         tile_py,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [TILE_AW-1:0]  tb_rd_addr,
  input  logic [63:0]         tb_rd_data,
  output logic [TILE_AW-1:0]  tb_wr_addr,
  output logic [63:0]         tb_wr_data,
  output logic                tb_wr_en,
  output logic                fb_valid,
  input  logic                fb_ready,
  output logic [15:0]         fb_x,
  output logic [15:0]         fb_y,
  output logic [31:0]         fb_rgba
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int XW = $clog2(TILE_W);

  wb_state_t          state_q;
  wb_state_t          state_d;
  logic [TILE_AW-1:0] rd_addr;
  logic [TILE_AW-1:0] cap_addr;
  logic               cap_valid;
  logic [15:0]        org_x;
  logic [15:0]        org_y;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [CW:0]        credit_used;
  logic               issue;
  logic               last_issue;
  logic               flush_last;
  logic               unused_full;
  fb_pixel_t          push_px;
  fb_pixel_t          head_px;

  // A read in flight already owns a FIFO slot, so the FIFO can never overflow.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, cap_valid};
  assign issue       = (state_q == WB_RUN) && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign last_issue  = issue && (rd_addr == TILE_AW'(TILE_PIXELS - 1));

  assign fb_valid = !fifo_empty;
  assign fifo_pop = fb_valid && fb_ready;

  // Looking ahead at the final accept lets done follow it on the very next cycle.
  assign flush_last = !cap_valid &&
                      (fifo_empty || (fifo_count == CW'(1) && fifo_pop));

  always_ff @(posedge clk) begin
    if (reset) state_q <= WB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE:  if (start) state_d = WB_RUN;
      WB_RUN:   if (last_issue) state_d = WB_FLUSH;
      WB_FLUSH: if (flush_last) state_d = WB_DONE;
      WB_DONE:  state_d = WB_IDLE;
      default:  state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr   <= '0;
      cap_addr  <= '0;
      cap_valid <= 1'b0;
      org_x     <= '0;
      org_y     <= '0;
    end else begin
      cap_valid <= issue;
      if (issue) begin
        cap_addr <= rd_addr;
        rd_addr  <= rd_addr + TILE_AW'(1);
      end
      if (state_q == WB_IDLE && start) begin
        org_x   <= tile_px;
        org_y   <= tile_py;
        rd_addr <= '0;
      end
    end
  end

  always_comb begin
    push_px      = '0;
    push_px.x    = org_x + 16'(cap_addr[XW-1:0]);
    push_px.y    = org_y + 16'(cap_addr[TILE_AW-1:XW]);
    push_px.rgba = {unorm10_to_u8(tb_rd_data[A_LSB +: CH_W]),
                    unorm10_to_u8(tb_rd_data[B_LSB +: CH_W]),
                    unorm10_to_u8(tb_rd_data[G_LSB +: CH_W]),
                    unorm10_to_u8(tb_rd_data[R_LSB +: CH_W])};
  end

  tile_wb_fifo #(
    .WIDTH($bits(fb_pixel_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cap_valid),
    .push_data (push_px),
    .pop       (fifo_pop),
    .head      (head_px),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign unused_full = fifo_full;

  assign busy       = (state_q != WB_IDLE);
  assign done       = (state_q == WB_DONE);
  assign tb_rd_addr = rd_addr;
  assign tb_wr_addr = cap_addr;
  assign tb_wr_en   = cap_valid;
  assign tb_wr_data = CLEAR_RGBA;
  assign fb_x       = head_px.x;
  assign fb_y       = head_px.y;
  assign fb_rgba    = head_px.rgba;

endmodule

// File: tb/tb_tile_writeback.sv
// Self-checking bench for tile_writeback: a tile buffer model feeds the block and a
// scoreboard of expected pixels is drained as the framebuffer side accepts them.
module tb_tile_writeback;

  localparam logic [63:0] CLEAR = 64'h0010_0020_0030_0040;

  logic        clk;
  logic        reset;
  logic [15:0] tile_px;
  logic [15:0] tile_py;
  logic        start;
  logic        busy;
  logic        done;
  logic [9:0]  tb_rd_addr;
  logic [63:0] tb_rd_data;
  logic [9:0]  tb_wr_addr;
  logic [63:0] tb_wr_data;
  logic        tb_wr_en;
  logic        fb_valid;
  logic        fb_ready;
  logic [15:0] fb_x;
  logic [15:0] fb_y;
  logic [31:0] fb_rgba;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] g;
    logic [15:0] b;
    logic [15:0] a;
    logic [31:0] rgba;
  } vec_t;

  vec_t        vec_tbl [6];
  logic [63:0] tbuf [1024];
  logic [31:0] exp_rgba [1024];
  logic [63:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_pct = 100;
  int wr_count = 0;
  int wr_seq = 0;
  int done_count = 0;
  int pop_count = 0;
  int max_cnt = 0;
  int px33_idx = -1;

  tile_writeback #(
    .CLEAR_RGBA(CLEAR),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tile_px    (tile_px),
    .tile_py    (tile_py),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .tb_rd_addr (tb_rd_addr),
    .tb_rd_data (tb_rd_data),
    .tb_wr_addr (tb_wr_addr),
    .tb_wr_data (tb_wr_data),
    .tb_wr_en   (tb_wr_en),
    .fb_valid   (fb_valid),
    .fb_ready   (fb_ready),
    .fb_x       (fb_x),
    .fb_y       (fb_y),
    .fb_rgba    (fb_rgba)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Tile buffer: one-cycle read latency, write port used by the clear strobe.
  always @(posedge clk) begin
    tb_rd_data <= tbuf[tb_rd_addr];
    if (tb_wr_en) tbuf[tb_wr_addr] <= tb_wr_data;
  end

  initial begin
    fb_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      fb_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  function automatic logic [7:0] to8(input logic [15:0] v);
    if (v >= 16'd1024) return 8'hFF;
    return 8'(v >> 2);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: scoreboard pops, stall stability, clear ordering, done counting.
  initial begin
    logic [63:0] e;
    logic        prev_stall;
    logic [15:0] prev_x;
    logic [15:0] prev_y;
    logic [31:0] prev_rgba;
    prev_stall = 1'b0;
    prev_x = '0;
    prev_y = '0;
    prev_rgba = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        wr_seq = 0;
        prev_stall = 1'b0;
      end else begin
        if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
        if (tb_wr_en) begin
          checkOutput("clear_order", 64'(tb_wr_addr), 64'(wr_seq));
          wr_seq = (wr_seq + 1) % 1024;
          wr_count++;
        end
        if (done) done_count++;
        if (prev_stall) begin
          checkOutput("stall_valid", 64'(fb_valid), 64'd1);
          checkOutput("stall_x", 64'(fb_x), 64'(prev_x));
          checkOutput("stall_y", 64'(fb_y), 64'(prev_y));
          checkOutput("stall_rgba", 64'(fb_rgba), 64'(prev_rgba));
        end
        if (fb_valid && fb_ready) begin
          checkOutput("pixel_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("pix_x", 64'(fb_x), 64'(e[63:48]));
            checkOutput("pix_y", 64'(fb_y), 64'(e[47:32]));
            checkOutput("pix_rgba", 64'(fb_rgba), 64'(e[31:0]));
          end
          if (pop_count == px33_idx) begin
            checkOutput("px33_x", 64'(fb_x), 64'd65);
            checkOutput("px33_y", 64'(fb_y), 64'd33);
            checkOutput("px33_rgba", 64'(fb_rgba), 64'hFF0880FF);
          end
          pop_count++;
        end
        prev_stall = fb_valid && !fb_ready;
        prev_x = fb_x;
        prev_y = fb_y;
        prev_rgba = fb_rgba;
      end
    end
  end

  // mode 0: fixed ramp pattern; 1: random; 2: conversion table vectors then random.
  task automatic loadTile(input int mode);
    logic [15:0] r, g, b, a;
    for (int n = 0; n < 1024; n++) begin
      if (mode == 0) begin
        r = 16'd1023; g = 16'd512; b = 16'(n); a = 16'd1020;
      end else begin
        r = (($urandom & 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1100));
        g = (($urandom & 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1100));
        b = (($urandom & 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1100));
        a = (($urandom & 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1100));
      end
      if (mode == 2 && n < 6) begin
        r = vec_tbl[n].r; g = vec_tbl[n].g; b = vec_tbl[n].b; a = vec_tbl[n].a;
        exp_rgba[n] = vec_tbl[n].rgba;
      end else begin
        exp_rgba[n] = {to8(a), to8(b), to8(g), to8(r)};
      end
      tbuf[n] <= {a, b, g, r};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkCleared();
    for (int n = 0; n < 1024; n++) checkOutput("clear_entry", tbuf[n], CLEAR);
  endtask

  task automatic applyStimulus(input logic [15:0] px, input logic [15:0] py, input int pct,
                               input int restart_at, input bit check_timing);
    int wr0, done0, pop0, start_cyc, done_cyc;
    bit got_done;
    ready_pct = pct;
    for (int n = 0; n < 1024; n++)
      exp_q.push_back({px + 16'(n % 32), py + 16'(n / 32), exp_rgba[n]});
    wr0 = wr_count;
    done0 = done_count;
    pop0 = pop_count;
    @(posedge clk);
    #1;
    start = 1'b1;
    tile_px = px;
    tile_py = py;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    tile_px = 16'hDEAD;
    tile_py = 16'hBEEF;
    if (check_timing) begin
      @(negedge clk);
      checkOutput("t1_busy", 64'(busy), 64'd1);
      checkOutput("t1_rd_addr", 64'(tb_rd_addr), 64'd0);
      @(negedge clk);
      checkOutput("t2_wr_en", 64'(tb_wr_en), 64'd1);
      checkOutput("t2_wr_addr", 64'(tb_wr_addr), 64'd0);
      checkOutput("t2_fb_valid", 64'(fb_valid), 64'd0);
      @(negedge clk);
      checkOutput("t3_fb_valid", 64'(fb_valid), 64'd1);
    end
    got_done = 1'b0;
    done_cyc = 0;
    for (int w = 0; w < 8000 && !got_done; w++) begin
      @(negedge clk);
      if (cyc - start_cyc == restart_at) begin
        start = 1'b1;
        tile_px = 16'h1111;
        tile_py = 16'h2222;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    checkOutput("done_seen", 64'(got_done), 64'd1);
    if (check_timing) checkOutput("done_latency", 64'(done_cyc - start_cyc), 64'd1027);
    checkOutput("done_busy", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("done_one_cycle", 64'(done), 64'd0);
    #1;
    checkOutput("done_count", 64'(done_count - done0), 64'd1);
    checkOutput("pixel_count", 64'(pop_count - pop0), 64'd1024);
    checkOutput("wr_en_count", 64'(wr_count - wr0), 64'd1024);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("fifo_max_le_depth", 64'(max_cnt <= 4), 64'd1);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    tile_px = '0;
    tile_py = '0;
    vec_tbl[0] = '{r:16'hFFFF, g:16'h0400, b:16'h03FF, a:16'h0000, rgba:32'h00FFFFFF};
    vec_tbl[1] = '{r:16'h0400, g:16'h0004, b:16'h0200, a:16'hFFFF, rgba:32'hFF8001FF};
    vec_tbl[2] = '{r:16'h0003, g:16'h1000, b:16'h8000, a:16'h0400, rgba:32'hFFFFFF00};
    vec_tbl[3] = '{r:16'h03FC, g:16'h0001, b:16'h0100, a:16'h0123, rgba:32'h484000FF};
    vec_tbl[4] = '{r:16'h0000, g:16'h0000, b:16'h0000, a:16'h0000, rgba:32'h00000000};
    vec_tbl[5] = '{r:16'h07FF, g:16'h0002, b:16'h0008, a:16'h03FB, rgba:32'hFE0200FF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_fb_valid", 64'(fb_valid), 64'd0);
    checkOutput("rst_wr_en", 64'(tb_wr_en), 64'd0);
    checkOutput("rst_rd_addr", 64'(tb_rd_addr), 64'd0);
    checkOutput("rst_wr_addr", 64'(tb_wr_addr), 64'd0);
    checkOutput("rst_wr_data", tb_wr_data, CLEAR);
    checkOutput("rst_fb_x", 64'(fb_x), 64'd0);
    checkOutput("rst_fb_y", 64'(fb_y), 64'd0);
    checkOutput("rst_fb_rgba", 64'(fb_rgba), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] run 1: ramp pattern, ready held high");
    loadTile(0);
    px33_idx = pop_count + 33;
    applyStimulus(16'd64, 16'd32, 100, -1, 1'b1);
    px33_idx = -1;
    checkCleared();

    $display("[TB] run 2: saturation table, 30%% ready, wrapping origin");
    loadTile(2);
    applyStimulus(16'hFFF0, 16'hFFF8, 30, -1, 1'b0);

    $display("[TB] run 3: second start at cycle 500 is ignored");
    loadTile(1);
    applyStimulus(16'd100, 16'd200, 100, 500, 1'b1);

    $display("[TB] run 4: reset with the FIFO full");
    loadTile(1);
    ready_pct = 0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    tile_px = 16'd5;
    tile_py = 16'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("pre_reset_fifo_count", 64'(dut.fifo_count), 64'd4);
    checkOutput("pre_reset_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_reset_fb_valid", 64'(fb_valid), 64'd0);
    checkOutput("post_reset_busy", 64'(busy), 64'd0);
    checkOutput("post_reset_wr_en", 64'(tb_wr_en), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();

    $display("[TB] run 5: fresh run after reset, 70%% ready");
    loadTile(1);
    applyStimulus(16'd7, 16'd9, 70, -1, 1'b0);
    checkCleared();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
